// File: rtl/ram_xfer_engine.sv
// RAM-to-RAM transfer sequencer: streams COPY (src->dst), FILL (pattern->dst) or
// CHECK (src vs pattern) one element per cycle, tracking in-flight reads in a shift pipeline.
module ram_xfer_engine #(
  parameter int AW     = 24,
  parameter int DW     = 32,
  parameter int LW     = 16,
  parameter int RD_LAT = 1
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          start_i,
  input  logic [1:0]    mode_i,
  input  logic          abort_i,
  input  logic [AW-1:0] src_base_i,
  input  logic [AW-1:0] dst_base_i,
  input  logic [LW-1:0] len_i,
  input  logic [DW-1:0] pattern_i,
  input  logic          pat_inc_i,
  output logic          busy_o,
  output logic          done_o,
  output logic          aborted_o,
  output logic [LW-1:0] err_cnt_o,
  output logic [AW-1:0] first_err_addr_o,
  output logic [AW-1:0] src_addr_o,
  output logic          src_ren_o,
  input  logic [DW-1:0] src_rdata_i,
  output logic [AW-1:0] dst_addr_o,
  output logic          dst_wen_o,
  output logic [DW-1:0] dst_wdata_o
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

  localparam logic [1:0] M_COPY  = 2'd0;
  localparam logic [1:0] M_FILL  = 2'd1;
  localparam logic [1:0] M_CHECK = 2'd2;
  localparam logic [RD_LAT-1:0] RET_BIT = RD_LAT'(1) << (RD_LAT - 1);

  state_t        state_q;
  logic [1:0]    mode_q;
  logic [AW-1:0] src_base_q, dst_base_q;
  logic [LW-1:0] len_q, idx_q, iss_idx_q;
  logic [DW-1:0] pattern_q;
  logic          pat_inc_q;
  logic [RD_LAT-1:0] vld_q;
  logic [LW-1:0] pidx_q [RD_LAT];

  logic          busy_q, done_q, aborted_q;
  logic [LW-1:0] err_cnt_q;
  logic [AW-1:0] first_err_q, src_addr_q, dst_addr_q;
  logic          src_ren_q, dst_wen_q;
  logic [DW-1:0] dst_wdata_q;

  logic          active, discard, ret_valid, reads_older, copy_pend, drained, last_issue, is_read;
  logic [LW-1:0] ret_idx, err_cnt_d;
  logic [DW-1:0] ret_pat_d, iss_pat_d;

  assign active      = (state_q == S_RUN) || (state_q == S_DRAIN);
  assign discard     = aborted_q || (abort_i && active);
  assign ret_valid   = vld_q[RD_LAT-1];
  assign ret_idx     = pidx_q[RD_LAT-1];
  assign reads_older = |(vld_q & ~RET_BIT);
  assign copy_pend   = (mode_q == M_COPY) && ret_valid && !discard;
  // Reads landing this edge in CHECK mode are consumed now; COPY needs one more cycle to write.
  assign drained     = !src_ren_q && !reads_older && !copy_pend;
  assign last_issue  = (idx_q + LW'(1)) == len_q;
  assign is_read     = (mode_q == M_COPY) || (mode_q == M_CHECK);
  assign ret_pat_d   = pattern_q + (pat_inc_q ? DW'(ret_idx) : '0);
  assign iss_pat_d   = pattern_q + (pat_inc_q ? DW'(idx_q) : '0);
  assign err_cnt_d   = (&err_cnt_q) ? err_cnt_q : err_cnt_q + LW'(1);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= S_IDLE;
      mode_q      <= '0;
      src_base_q  <= '0;
      dst_base_q  <= '0;
      len_q       <= '0;
      idx_q       <= '0;
      iss_idx_q   <= '0;
      pattern_q   <= '0;
      pat_inc_q   <= 1'b0;
      vld_q       <= '0;
      for (int k = 0; k < RD_LAT; k++) pidx_q[k] <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      aborted_q   <= 1'b0;
      err_cnt_q   <= '0;
      first_err_q <= '0;
      src_addr_q  <= '0;
      src_ren_q   <= 1'b0;
      dst_addr_q  <= '0;
      dst_wen_q   <= 1'b0;
      dst_wdata_q <= '0;
    end else begin
      src_ren_q <= 1'b0;
      dst_wen_q <= 1'b0;
      done_q    <= 1'b0;

      for (int k = RD_LAT - 1; k > 0; k--) begin
        vld_q[k]  <= vld_q[k-1];
        pidx_q[k] <= pidx_q[k-1];
      end
      vld_q[0]  <= src_ren_q;
      pidx_q[0] <= iss_idx_q;

      if (ret_valid && !discard) begin
        if (mode_q == M_COPY) begin
          dst_wen_q   <= 1'b1;
          dst_addr_q  <= dst_base_q + AW'(ret_idx);
          dst_wdata_q <= src_rdata_i;
        end else if ((mode_q == M_CHECK) && (src_rdata_i != ret_pat_d)) begin
          err_cnt_q <= err_cnt_d;
          if (err_cnt_q == '0) first_err_q <= src_base_q + AW'(ret_idx);
        end
      end

      case (state_q)
        S_IDLE: begin
          if (start_i) begin
            mode_q      <= (mode_i == 2'd3) ? M_FILL : mode_i;
            src_base_q  <= src_base_i;
            dst_base_q  <= dst_base_i;
            len_q       <= len_i;
            pattern_q   <= pattern_i;
            pat_inc_q   <= pat_inc_i;
            idx_q       <= '0;
            aborted_q   <= 1'b0;
            err_cnt_q   <= '0;
            first_err_q <= '0;
            busy_q      <= 1'b1;
            state_q     <= S_RUN;
          end
        end
        S_RUN: begin
          if (abort_i) begin
            aborted_q <= 1'b1;
            state_q   <= S_DRAIN;
          end else if (idx_q == len_q) begin
            state_q <= S_DRAIN;
          end else begin
            idx_q <= idx_q + LW'(1);
            if (last_issue) state_q <= S_DRAIN;
            if (is_read) begin
              src_ren_q  <= 1'b1;
              src_addr_q <= src_base_q + AW'(idx_q);
              iss_idx_q  <= idx_q;
            end else begin
              dst_wen_q   <= 1'b1;
              dst_addr_q  <= dst_base_q + AW'(idx_q);
              dst_wdata_q <= iss_pat_d;
            end
          end
        end
        S_DRAIN: begin
          if (abort_i) aborted_q <= 1'b1;
          if (drained) begin
            done_q  <= 1'b1;
            state_q <= S_DONE;
          end
        end
        S_DONE: begin
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign busy_o           = busy_q;
  assign done_o           = done_q;
  assign aborted_o        = aborted_q;
  assign err_cnt_o        = err_cnt_q;
  assign first_err_addr_o = first_err_q;
  assign src_addr_o       = src_addr_q;
  assign src_ren_o        = src_ren_q;
  assign dst_addr_o       = dst_addr_q;
  assign dst_wen_o        = dst_wen_q;
  assign dst_wdata_o      = dst_wdata_q;

endmodule

// File: tb/tb_ram_xfer_engine.sv
// Scoreboard bench for ram_xfer_engine: two instances (RD_LAT 1 and 3) share one command stream;
// per-instance monitors pop expected reads, writes and done events with their exact cycle.
module tb_ram_xfer_engine;
  localparam int AW = 24;
  localparam int DW = 32;
  localparam int LW = 16;

  typedef struct {int c; logic [AW-1:0] a; logic [DW-1:0] d;} acc_t;
  typedef struct {int c; logic ab; logic [LW-1:0] e; logic [AW-1:0] f;} dn_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_n, start, abort, pat_inc;
  logic [1:0]    mode;
  logic [AW-1:0] src_base, dst_base;
  logic [LW-1:0] len;
  logic [DW-1:0] pattern;

  logic          busy [2], done [2], aborted [2], src_ren [2], dst_wen [2];
  logic [LW-1:0] err_cnt [2];
  logic [AW-1:0] fea [2], src_addr [2], dst_addr [2];
  logic [DW-1:0] dst_wdata [2], src_rdata [2];

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  ram_xfer_engine #(.AW(AW), .DW(DW), .LW(LW), .RD_LAT(1)) u_dut_l1 (
    .clk_i(clk), .rst_ni(rst_n), .start_i(start), .mode_i(mode), .abort_i(abort),
    .src_base_i(src_base), .dst_base_i(dst_base), .len_i(len), .pattern_i(pattern),
    .pat_inc_i(pat_inc), .busy_o(busy[0]), .done_o(done[0]), .aborted_o(aborted[0]),
    .err_cnt_o(err_cnt[0]), .first_err_addr_o(fea[0]), .src_addr_o(src_addr[0]),
    .src_ren_o(src_ren[0]), .src_rdata_i(src_rdata[0]), .dst_addr_o(dst_addr[0]),
    .dst_wen_o(dst_wen[0]), .dst_wdata_o(dst_wdata[0]));

  ram_xfer_engine #(.AW(AW), .DW(DW), .LW(LW), .RD_LAT(3)) u_dut_l3 (
    .clk_i(clk), .rst_ni(rst_n), .start_i(start), .mode_i(mode), .abort_i(abort),
    .src_base_i(src_base), .dst_base_i(dst_base), .len_i(len), .pattern_i(pattern),
    .pat_inc_i(pat_inc), .busy_o(busy[1]), .done_o(done[1]), .aborted_o(aborted[1]),
    .err_cnt_o(err_cnt[1]), .first_err_addr_o(fea[1]), .src_addr_o(src_addr[1]),
    .src_ren_o(src_ren[1]), .src_rdata_i(src_rdata[1]), .dst_addr_o(dst_addr[1]),
    .dst_wen_o(dst_wen[1]), .dst_wdata_o(dst_wdata[1]));

  // Source RAM model; read data is only valid for the one cycle the engine should sample it.
  logic [DW-1:0] mem [logic [AW-1:0]];
  logic [DW-1:0] rp1;
  logic [DW-1:0] rp3 [3];

  function automatic logic [DW-1:0] rd(input logic [AW-1:0] a);
    if (mem.exists(a)) return mem[a];
    return 32'hBAD0_BAD0;
  endfunction

  always @(posedge clk) begin
    rp1    <= src_ren[0] ? rd(src_addr[0]) : 32'hBAD0_BAD0;
    rp3[0] <= src_ren[1] ? rd(src_addr[1]) : 32'hBAD0_BAD0;
    rp3[1] <= rp3[0];
    rp3[2] <= rp3[1];
  end
  assign src_rdata[0] = rp1;
  assign src_rdata[1] = rp3[2];

  acc_t rd_q0[$], rd_q1[$], wr_q0[$], wr_q1[$];
  dn_t  dn_q0[$], dn_q1[$];

  function automatic int lat(input int k);
    return (k == 0) ? 1 : 3;
  endfunction

  function automatic void push_rd(input int k, input int c, input logic [AW-1:0] a);
    acc_t x = '{c, a, '0};
    if (k == 0) rd_q0.push_back(x); else rd_q1.push_back(x);
  endfunction

  function automatic void push_wr(input int k, input int c, input logic [AW-1:0] a, input logic [DW-1:0] d);
    acc_t x = '{c, a, d};
    if (k == 0) wr_q0.push_back(x); else wr_q1.push_back(x);
  endfunction

  function automatic void push_dn(input int k, input int c, input logic ab, input logic [LW-1:0] e, input logic [AW-1:0] f);
    dn_t x = '{c, ab, e, f};
    if (k == 0) dn_q0.push_back(x); else dn_q1.push_back(x);
  endfunction

  function automatic bit pop_rd(input int k, output acc_t x);
    x = '{0, '0, '0};
    if (k == 0) begin if (rd_q0.size() == 0) return 0; x = rd_q0.pop_front(); end
    else begin if (rd_q1.size() == 0) return 0; x = rd_q1.pop_front(); end
    return 1;
  endfunction

  function automatic bit pop_wr(input int k, output acc_t x);
    x = '{0, '0, '0};
    if (k == 0) begin if (wr_q0.size() == 0) return 0; x = wr_q0.pop_front(); end
    else begin if (wr_q1.size() == 0) return 0; x = wr_q1.pop_front(); end
    return 1;
  endfunction

  function automatic bit pop_dn(input int k, output dn_t x);
    x = '{0, 1'b0, '0, '0};
    if (k == 0) begin if (dn_q0.size() == 0) return 0; x = dn_q0.pop_front(); end
    else begin if (dn_q1.size() == 0) return 0; x = dn_q1.pop_front(); end
    return 1;
  endfunction

  function automatic int left(input int k);
    return (k == 0) ? rd_q0.size() + wr_q0.size() : rd_q1.size() + wr_q1.size();
  endfunction

  function automatic void clear_all();
    rd_q0.delete(); rd_q1.delete(); wr_q0.delete(); wr_q1.delete();
    dn_q0.delete(); dn_q1.delete();
  endfunction

  task automatic mon(input int k);
    acc_t x;
    dn_t  y;
    if (src_ren[k]) begin
      checks++;
      if (!pop_rd(k, x)) begin
        errors++;
        $display("FAIL rd_unexpected inst%0d cyc %0d: got addr %h, want no read", k, cyc, src_addr[k]);
      end else if (x.a !== src_addr[k] || x.c != cyc) begin
        errors++;
        $display("FAIL rd inst%0d: got addr %h at cyc %0d, want addr %h at cyc %0d", k, src_addr[k], cyc, x.a, x.c);
      end
    end
    if (dst_wen[k]) begin
      checks++;
      if (!pop_wr(k, x)) begin
        errors++;
        $display("FAIL wr_unexpected inst%0d cyc %0d: got addr %h data %h, want no write", k, cyc, dst_addr[k], dst_wdata[k]);
      end else if (x.a !== dst_addr[k] || x.d !== dst_wdata[k] || x.c != cyc) begin
        errors++;
        $display("FAIL wr inst%0d: got %h<=%h at cyc %0d, want %h<=%h at cyc %0d",
                 k, dst_addr[k], dst_wdata[k], cyc, x.a, x.d, x.c);
      end
    end
    if (done[k]) begin
      checks++;
      if (!pop_dn(k, y)) begin
        errors++;
        $display("FAIL done_unexpected inst%0d cyc %0d", k, cyc);
      end else if (y.c != cyc || y.ab !== aborted[k] || y.e !== err_cnt[k] || y.f !== fea[k]
                   || busy[k] !== 1'b1 || left(k) != 0) begin
        errors++;
        $display("FAIL done inst%0d: got cyc %0d ab %b err %0d fea %h busy %b pending %0d, want cyc %0d ab %b err %0d fea %h busy 1 pending 0",
                 k, cyc, aborted[k], err_cnt[k], fea[k], busy[k], left(k), y.c, y.ab, y.e, y.f);
      end
    end
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      mon(0);
      mon(1);
    end
  end

  task automatic chk_zero(input string nm, input int k);
    checks++;
    if ({busy[k], done[k], aborted[k], err_cnt[k], fea[k], src_addr[k], src_ren[k],
         dst_addr[k], dst_wen[k], dst_wdata[k]} !== '0) begin
      errors++;
      $display("FAIL %s inst%0d: got busy %b done %b ren %b wen %b sa %h da %h wd %h err %0d, want all 0",
               nm, k, busy[k], done[k], src_ren[k], dst_wen[k], src_addr[k], dst_addr[k], dst_wdata[k], err_cnt[k]);
    end
  endtask

  task automatic cmd(input logic [1:0] m, input logic [AW-1:0] sb, input logic [AW-1:0] db,
                     input logic [LW-1:0] n, input logic [DW-1:0] p, input logic inc, output int acc);
    @(negedge clk);
    mode = m; src_base = sb; dst_base = db; len = n; pattern = p; pat_inc = inc;
    start = 1'b1;
    acc = cyc + 1;
  endtask

  task automatic wait_all(input int budget);
    int n = 0;
    @(negedge clk);
    start = 1'b0;
    abort = 1'b0;
    while ((dn_q0.size() != 0 || dn_q1.size() != 0) && n < budget) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (n >= budget) begin
      errors++;
      $display("FAIL timeout: got %0d/%0d done events pending after %0d cycles, want 0", dn_q0.size(), dn_q1.size(), budget);
      clear_all();
    end
  endtask

  initial begin
    int acc;
    rst_n = 1'b0; start = 1'b0; abort = 1'b0; mode = '0; pat_inc = 1'b0;
    src_base = '0; dst_base = '0; len = '0; pattern = '0;
    for (int i = 0; i < 16; i++) mem[AW'(24'h654321 + i)] = DW'(32'hC0DE_0000 + 32'h0101 * i);
    for (int i = 0; i < 8; i++) mem[AW'(24'h000200 + i)] = 32'hDEAD_BEEF;
    mem[24'h000202] = 32'h0BAD_F00D;
    mem[24'h000205] = 32'hDEAD_BEEE;
    mem[24'h000400] = 32'hFFFF_FFFE; mem[24'h000401] = 32'hFFFF_FFFF;
    mem[24'h000402] = 32'h0000_0000; mem[24'h000403] = 32'h0000_0001;
    mem[24'hFFFFFE] = 32'h1111_1111; mem[24'hFFFFFF] = 32'h2222_2222;
    mem[24'h000000] = 32'h3333_3333; mem[24'h000001] = 32'h4444_4444;

    repeat (3) @(negedge clk);
    chk_zero("reset", 0);
    chk_zero("reset", 1);
    rst_n = 1'b1;
    @(negedge clk);

    // FILL with incrementing pattern
    cmd(2'd1, '0, 24'h123456, 16'd4, 32'h0000_00A0, 1'b1, acc);
    for (int k = 0; k < 2; k++) begin
      for (int i = 0; i < 4; i++) push_wr(k, acc + 1 + i, AW'(24'h123456 + i), DW'(32'hA0 + i));
      push_dn(k, acc + 5, 1'b0, '0, '0);
    end
    wait_all(60);

    // COPY len 8
    cmd(2'd0, 24'h654321, 24'h000100, 16'd8, '0, 1'b0, acc);
    for (int k = 0; k < 2; k++) begin
      for (int i = 0; i < 8; i++) begin
        push_rd(k, acc + 1 + i, AW'(24'h654321 + i));
        push_wr(k, acc + 2 + lat(k) + i, AW'(24'h000100 + i), DW'(32'hC0DE_0000 + 32'h0101 * i));
      end
      push_dn(k, acc + 10 + lat(k), 1'b0, '0, '0);
    end
    wait_all(60);

    // CHECK constant pattern, words 2 and 5 corrupted
    cmd(2'd2, 24'h000200, 24'h000900, 16'd8, 32'hDEAD_BEEF, 1'b0, acc);
    for (int k = 0; k < 2; k++) begin
      for (int i = 0; i < 8; i++) push_rd(k, acc + 1 + i, AW'(24'h000200 + i));
      push_dn(k, acc + 9 + lat(k), 1'b0, 16'd2, 24'h000202);
    end
    wait_all(60);

    // CHECK incrementing pattern that wraps through zero, no mismatches
    cmd(2'd2, 24'h000400, 24'h000900, 16'd4, 32'hFFFF_FFFE, 1'b1, acc);
    for (int k = 0; k < 2; k++) begin
      for (int i = 0; i < 4; i++) push_rd(k, acc + 1 + i, AW'(24'h000400 + i));
      push_dn(k, acc + 5 + lat(k), 1'b0, '0, '0);
    end
    wait_all(60);

    // COPY with source and destination address wrap
    cmd(2'd0, 24'hFFFFFE, 24'hFFFFFF, 16'd4, '0, 1'b0, acc);
    for (int k = 0; k < 2; k++) begin
      push_rd(k, acc + 1, 24'hFFFFFE); push_rd(k, acc + 2, 24'hFFFFFF);
      push_rd(k, acc + 3, 24'h000000); push_rd(k, acc + 4, 24'h000001);
      push_wr(k, acc + 2 + lat(k), 24'hFFFFFF, 32'h1111_1111);
      push_wr(k, acc + 3 + lat(k), 24'h000000, 32'h2222_2222);
      push_wr(k, acc + 4 + lat(k), 24'h000001, 32'h3333_3333);
      push_wr(k, acc + 5 + lat(k), 24'h000002, 32'h4444_4444);
      push_dn(k, acc + 6 + lat(k), 1'b0, '0, '0);
    end
    wait_all(60);

    // len=0 in COPY and FILL: no enables, done two cycles after start
    cmd(2'd0, 24'h654321, 24'h000100, 16'd0, '0, 1'b0, acc);
    for (int k = 0; k < 2; k++) push_dn(k, acc + 2, 1'b0, '0, '0);
    wait_all(20);
    cmd(2'd1, '0, 24'h000100, 16'd0, 32'h1234_5678, 1'b0, acc);
    for (int k = 0; k < 2; k++) push_dn(k, acc + 2, 1'b0, '0, '0);
    wait_all(20);

    // COPY len 16 aborted in cycle 3; a start held while busy must be ignored
    cmd(2'd0, 24'h654321, 24'h000100, 16'd16, '0, 1'b0, acc);
    for (int k = 0; k < 2; k++) begin
      push_rd(k, acc + 1, 24'h654321);
      push_rd(k, acc + 2, 24'h654322);
      push_dn(k, acc + 3 + lat(k), 1'b1, '0, '0);
    end
    @(negedge clk);
    mode = 2'd1; dst_base = 24'hABCDEF; len = 16'd5;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    abort = 1'b1;
    wait_all(60);

    // Reserved mode runs as FILL; abort coinciding with start is ignored, aborted clears
    @(negedge clk);
    mode = 2'd3; src_base = '0; dst_base = 24'h000800; len = 16'd3; pattern = 32'h55; pat_inc = 1'b0;
    start = 1'b1; abort = 1'b1;
    acc = cyc + 1;
    for (int k = 0; k < 2; k++) begin
      for (int i = 0; i < 3; i++) push_wr(k, acc + 1 + i, AW'(24'h000800 + i), 32'h0000_0055);
      push_dn(k, acc + 4, 1'b0, '0, '0);
    end
    wait_all(60);

    // Asynchronous reset in the middle of a COPY
    cmd(2'd0, 24'h654321, 24'h000500, 16'd16, '0, 1'b0, acc);
    for (int k = 0; k < 2; k++) begin
      for (int i = 0; i < 16; i++) begin
        push_rd(k, acc + 1 + i, AW'(24'h654321 + i));
        push_wr(k, acc + 2 + lat(k) + i, AW'(24'h000500 + i), DW'(32'hC0DE_0000 + 32'h0101 * i));
      end
    end
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk_zero("async_rst", 0);
    chk_zero("async_rst", 1);
    clear_all();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    chk_zero("post_rst_idle", 0);
    chk_zero("post_rst_idle", 1);

    cmd(2'd0, 24'h654321, 24'h000900, 16'd3, '0, 1'b0, acc);
    for (int k = 0; k < 2; k++) begin
      for (int i = 0; i < 3; i++) begin
        push_rd(k, acc + 1 + i, AW'(24'h654321 + i));
        push_wr(k, acc + 2 + lat(k) + i, AW'(24'h000900 + i), DW'(32'hC0DE_0000 + 32'h0101 * i));
      end
      push_dn(k, acc + 5 + lat(k), 1'b0, '0, '0);
    end
    wait_all(60);
    repeat (3) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
